memory_controller: RTL and testbench
====================================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameter QUEUE_DEPTH, default 8: request queue entries, power of two.
REQ-002 Parameter MEM_WORDS, default 1024: storage depth in data words, power of two.
REQ-003 Parameter READ_LATENCY, default 2: storage array read cycles, range 1..7.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_req  input  request_t  request from the interconnect; fields used are vld, core_id, opcode (READ/WRITE), addr, data.
REQ-007 mem_rsp  output  request_t  registered response to the interconnect; core_id copied from the originating request.
REQ-008 req_full  output  1  queue holds QUEUE_DEPTH entries.
REQ-009 queue_count  output  $clog2(QUEUE_DEPTH)+1  current queue occupancy.
REQ-010 overflow_err  output  1  sticky flag; a request was dropped.

Function
REQ-011 The block shall push mem_req into the FIFO queue on any cycle with mem_req.vld=1 and either (not full) or (a pop in the same cycle).
REQ-012 The block shall drop mem_req.vld=1 when full with no same-cycle pop, and set overflow_err=1 on the next cycle, held until reset.
REQ-013 Read and write pointers shall wrap modulo QUEUE_DEPTH; queue_count shall remain exact under simultaneous push and pop.
REQ-014 FSM states: IDLE, ACCESS, RESPOND.
REQ-015 IDLE: if the queue is not empty, pop the head into a holding register and go to ACCESS; otherwise stay in IDLE.
REQ-016 ACCESS, WRITE: write data to storage[addr mod MEM_WORDS] on the first ACCESS cycle, then go to RESPOND.
REQ-017 ACCESS, READ: load a latency counter with READ_LATENCY, decrement it each cycle, and go to RESPOND when it reaches 1.
REQ-018 RESPOND: drive mem_rsp for exactly one cycle, then go to IDLE.
REQ-019 The read response shall be vld=1, opcode=READ, core_id, addr, and data=stored word.
REQ-020 The write response shall be vld=1, opcode=WRITE, core_id, addr, and data=0.
REQ-021 mem_rsp.vld shall be 0 on every cycle not in RESPOND, with all other mem_rsp fields 0.
REQ-022 Pop-to-response latency shall be READ_LATENCY+1 cycles for a read and 2 cycles for a write.
REQ-023 A new pop shall occur only in IDLE; requests shall be served one at a time and in arrival order.
REQ-024 addr bits above $clog2(MEM_WORDS) shall be ignored (address wrap-around); no error shall be raised.
REQ-025 A read after a write to the same address, queued later, shall return the written data.
REQ-026 A request arriving on the same cycle the queue becomes non-full shall be accepted.

Reset
REQ-027 On reset=1 at a rising edge, the block shall clear the pointers, queue_count, req_full, overflow_err, mem_rsp, the latency counter and the holding register, and set the FSM to IDLE.
REQ-028 A reset during ACCESS or RESPOND shall abort the in-flight request: no response, no further write.
REQ-029 Storage contents shall not be reset; a read of a never-written word returns an undefined value.
REQ-030 mem_req shall be ignored on the reset cycle.

Structure
REQ-031 request_t, its opcode enum (READ/WRITE), NUM_OF_CORES and the data/address widths shall live in the shared package.
REQ-032 The queue shall be a separate sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count).
REQ-033 Storage shall be a flop or inferred-RAM array inside memory_controller, with no reset on the array.

Verification
REQ-034 After reset, WRITE core_id=2, addr=0x010, data=0xDEAD_BEEF, then READ core_id=1, addr=0x010 -> write ack to core 2 with data=0, then read response to core 1 with data=0xDEAD_BEEF, in order.
REQ-035 Single READ popped at cycle T with READ_LATENCY=2 -> mem_rsp.vld=1 at T+3 only.
REQ-036 Ten back-to-back requests with no drain, QUEUE_DEPTH=8 -> req_full=1, queue_count=8, overflow_err=1, and exactly the dropped requests receive no response.
REQ-037 Queue full with a push and pop in the same cycle -> push accepted, queue_count stays 8, overflow_err stays 0.
REQ-038 WRITE addr=0x410 data=0x5, then READ addr=0x010, MEM_WORDS=1024 -> read data=0x5 (wrap-around).
REQ-039 Reset asserted mid-ACCESS of a read, with 3 entries queued -> no mem_rsp.vld, queue_count=0, FSM IDLE on the cycle after reset.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the memory controller slice.
// Contents:
//   NUM_OF_CORES / CORE_ID_W  number of requesting cores and the id width
//   ADDR_W / DATA_W           request address and data widths
//   opcode_e                  READ / WRITE
//   request_t                 request/response record used on both directions
//   state_e                   controller FSM states
//   make_rsp()                builds a response record from a served request
package memory_controller_pkg;

  localparam int NUM_OF_CORES = 4;
  localparam int CORE_ID_W    = $clog2(NUM_OF_CORES);
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int LAT_W        = 3;   // holds READ_LATENCY up to 7

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } opcode_e;

  typedef struct packed {
    logic                 vld;
    logic [CORE_ID_W-1:0] core_id;
    opcode_e              opcode;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
  } request_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  // A response echoes core_id, opcode and the full (unwrapped) address of
  // the request it answers; only the data field is replaced.
  function automatic request_t make_rsp(request_t req, logic [DATA_W-1:0] data);
    request_t r;
    r      = req;
    r.vld  = 1'b1;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/memory_controller_fifo.sv
// sync_fifo: single-clock first-in first-out request queue.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   push, din    write an entry (accepted when not full, or when full with a
//                same-cycle pop, which frees the head slot)
//   pop, dout    remove the head entry; dout always shows the head (show-ahead)
//   full, empty  occupancy flags
//   count        exact occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/memory_controller.sv
// memory_controller: queues interconnect requests and serves them one at a
// time, in arrival order, against a local word-addressed storage array.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   mem_req       incoming request (vld, core_id, opcode, addr, data)
//   mem_rsp       registered response, valid for exactly one cycle per request;
//                 all fields are zero when no response is presented
//   req_full      request queue is full
//   queue_count   request queue occupancy
//   overflow_err  sticky: a request was dropped because the queue was full
// Parameters: QUEUE_DEPTH (power of two), MEM_WORDS (power of two),
//             READ_LATENCY (1..7 storage read cycles).
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 8,
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  request_t                     mem_req,
  output request_t                     mem_rsp,
  output logic                         req_full,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic                         overflow_err
);

  localparam int               MEM_AW   = $clog2(MEM_WORDS);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  request_t    fifo_dout;

  state_e            state_q, state_d;
  request_t          hold_q, hold_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  request_t          rsp_q, rsp_d;
  logic              overflow_q, overflow_d;
  logic              wr_en;

  logic [DATA_W-1:0] storage [MEM_WORDS];
  logic [DATA_W-1:0] rd_word;

  sync_fifo #(
    .WIDTH ($bits(request_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mem_req),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (queue_count)
  );

  // Upper address bits are dropped, so addresses alias modulo MEM_WORDS.
  assign rd_word = storage[hold_q.addr[MEM_AW-1:0]];

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    lat_cnt_d  = lat_cnt_q;
    rsp_d      = '0;
    overflow_d = overflow_q;
    fifo_pop   = 1'b0;
    wr_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          hold_d    = fifo_dout;
          // Loaded here so the first ACCESS cycle already sees READ_LATENCY.
          lat_cnt_d = LAT_LOAD;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (hold_q.opcode == WRITE) begin
          wr_en   = 1'b1;
          rsp_d   = make_rsp(hold_q, '0);
          state_d = RESPOND;
        end else if (lat_cnt_q <= LAT_W'(1)) begin
          // Response is registered on the way into RESPOND so that it is
          // visible exactly while the FSM sits in RESPOND.
          rsp_d   = make_rsp(hold_q, rd_word);
          state_d = RESPOND;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A full queue still accepts a request when the head leaves this cycle.
    fifo_push = mem_req.vld && (!fifo_full || fifo_pop);
    if (mem_req.vld && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      lat_cnt_q  <= '0;
      rsp_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      lat_cnt_q  <= lat_cnt_d;
      rsp_q      <= rsp_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; a reset in ACCESS suppresses the pending write.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) storage[hold_q.addr[MEM_AW-1:0]] <= hold_q.data;
  end

  assign mem_rsp      = rsp_q;
  assign req_full     = fifo_full;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed testbench for memory_controller. Two instances share clock and
// reset: u_dut uses default parameters, u_slow uses READ_LATENCY=7 so that
// the queue can be driven to full while the controller is busy.
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  request_t   req_a, req_b, rsp_a, rsp_b;
  logic       full_a, full_b, ovf_a, ovf_b;
  logic [3:0] cnt_a, cnt_b;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int idle_bad = 0;
  bit mon_en   = 1'b0;

  request_t rsp_a_q[$];
  request_t rsp_b_q[$];
  int       cyc_a_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_controller u_dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (req_a),
    .mem_rsp      (rsp_a),
    .req_full     (full_a),
    .queue_count  (cnt_a),
    .overflow_err (ovf_a)
  );

  memory_controller #(.READ_LATENCY(7)) u_slow (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (req_b),
    .mem_rsp      (rsp_b),
    .req_full     (full_b),
    .queue_count  (cnt_b),
    .overflow_err (ovf_b)
  );

  // Response collectors; also count non-zero fields outside a response.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (rsp_a.vld) begin
        rsp_a_q.push_back(rsp_a);
        cyc_a_q.push_back(cyc);
      end else if (rsp_a != '0) begin
        idle_bad++;
      end
      if (rsp_b.vld) rsp_b_q.push_back(rsp_b);
      else if (rsp_b != '0) idle_bad++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic request_t mk(opcode_e op, logic [1:0] core, logic [31:0] addr,
                                  logic [31:0] data);
    request_t r;
    r.vld     = 1'b1;
    r.core_id = core;
    r.opcode  = op;
    r.addr    = addr;
    r.data    = data;
    return r;
  endfunction

  task automatic check_rsp(input string tag, input request_t got, input opcode_e op,
                           input logic [1:0] core, input logic [31:0] addr,
                           input logic [31:0] data);
    check({tag, "_core"}, 64'(got.core_id), 64'(core));
    check({tag, "_op"},   64'(got.opcode),  64'(op));
    check({tag, "_addr"}, 64'(got.addr),    64'(addr));
    check({tag, "_data"}, 64'(got.data),    64'(data));
  endtask

  function automatic request_t rsp_a_at(int i);
    return (i < rsp_a_q.size()) ? rsp_a_q[i] : request_t'('0);
  endfunction

  function automatic request_t rsp_b_at(int i);
    return (i < rsp_b_q.size()) ? rsp_b_q[i] : request_t'('0);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    reset = 1'b0;
    rsp_a_q.delete();
    rsp_b_q.delete();
    cyc_a_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    do_reset();
    mon_en = 1'b1;

    // Reset state
    check("rst_rsp",  64'(rsp_a),  64'(0));
    check("rst_full", 64'(full_a), 64'(0));
    check("rst_cnt",  64'(cnt_a),  64'(0));
    check("rst_ovf",  64'(ovf_a),  64'(0));

    // Write then read of the same address, served in order
    req_a = mk(WRITE, 2'd2, 32'h010, 32'hDEAD_BEEF);
    tick();
    req_a = mk(READ, 2'd1, 32'h010, 32'h0);
    tick();
    req_a = '0;
    repeat (12) tick();
    check("wr_rd_count", 64'(rsp_a_q.size()), 64'(2));
    check_rsp("wr_ack",  rsp_a_at(0), WRITE, 2'd2, 32'h010, 32'h0);
    check_rsp("rd_back", rsp_a_at(1), READ,  2'd1, 32'h010, 32'hDEAD_BEEF);

    // Read latency: pushed in k0, popped in k0+1, response only in k0+4
    rsp_a_q.delete();
    cyc_a_q.delete();
    k0    = cyc;
    req_a = mk(READ, 2'd3, 32'h010, 32'h0);
    tick();
    req_a = '0;
    repeat (10) tick();
    check("rd_lat_count", 64'(rsp_a_q.size()), 64'(1));
    check("rd_lat_cycle", 64'((cyc_a_q.size() > 0) ? cyc_a_q[0] : -1), 64'(k0 + 4));
    check_rsp("rd_lat", rsp_a_at(0), READ, 2'd3, 32'h010, 32'hDEAD_BEEF);

    // Write latency: popped in k0+1, response only in k0+3
    rsp_a_q.delete();
    cyc_a_q.delete();
    k0    = cyc;
    req_a = mk(WRITE, 2'd0, 32'h020, 32'h1234);
    tick();
    req_a = '0;
    repeat (10) tick();
    check("wr_lat_count", 64'(rsp_a_q.size()), 64'(1));
    check("wr_lat_cycle", 64'((cyc_a_q.size() > 0) ? cyc_a_q[0] : -1), 64'(k0 + 3));

    // Address wrap-around: 0x410 aliases 0x010 with 1024 words
    rsp_a_q.delete();
    req_a = mk(WRITE, 2'd1, 32'h410, 32'h5);
    tick();
    req_a = mk(READ, 2'd2, 32'h010, 32'h0);
    tick();
    req_a = '0;
    repeat (12) tick();
    check("wrap_count", 64'(rsp_a_q.size()), 64'(2));
    check_rsp("wrap_wr", rsp_a_at(0), WRITE, 2'd1, 32'h410, 32'h0);
    check_rsp("wrap_rd", rsp_a_at(1), READ,  2'd2, 32'h010, 32'h5);
    check("wrap_no_err", 64'(ovf_a), 64'(0));

    // Ten back-to-back reads into the slow instance: r9 is dropped
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req_b = mk(READ, 2'(i), 32'(i), 32'h0);
      tick();
    end
    req_b = '0;
    check("ovf_full", 64'(full_b), 64'(1));
    check("ovf_cnt",  64'(cnt_b),  64'(8));
    check("ovf_flag", 64'(ovf_b),  64'(1));
    repeat (120) tick();
    check("ovf_rsp_count", 64'(rsp_b_q.size()), 64'(9));
    for (int i = 0; i < 9; i++) check("ovf_rsp_addr", 64'(rsp_b_at(i).addr), 64'(i));
    check("ovf_sticky", 64'(ovf_b), 64'(1));
    check("ovf_drained", 64'(cnt_b), 64'(0));

    // Full queue with push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req_b = mk(READ, 2'(i), 32'(i), 32'h0);
      tick();
    end
    req_b = '0;
    tick();
    check("pp_pre_full", 64'(full_b), 64'(1));
    check("pp_pre_cnt",  64'(cnt_b),  64'(8));
    req_b = mk(READ, 2'd2, 32'h0A, 32'h0);
    tick();
    req_b = '0;
    check("pp_cnt",  64'(cnt_b),  64'(8));
    check("pp_full", 64'(full_b), 64'(1));
    check("pp_ovf",  64'(ovf_b),  64'(0));
    repeat (120) tick();
    check("pp_rsp_count", 64'(rsp_b_q.size()), 64'(10));
    check("pp_last_addr", 64'(rsp_b_at(9).addr), 64'(32'h0A));

    // Reset during ACCESS with three requests still queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_b = mk(READ, 2'd1, 32'(32'h40 + i), 32'h0);
      tick();
    end
    check("rst_mid_pre_cnt", 64'(cnt_b), 64'(3));
    reset = 1'b1;
    req_b = mk(READ, 2'd3, 32'h77, 32'h0);
    tick();
    check("rst_mid_cnt",   64'(cnt_b),         64'(0));
    check("rst_mid_vld",   64'(rsp_b.vld),     64'(0));
    check("rst_mid_state", 64'(u_slow.state_q), 64'(IDLE));
    reset = 1'b0;
    req_b = '0;
    repeat (20) tick();
    check("rst_mid_no_rsp", 64'(rsp_b_q.size()), 64'(0));
    req_b = mk(WRITE, 2'd0, 32'h50, 32'h9);
    tick();
    req_b = '0;
    repeat (6) tick();
    check("rst_mid_resume", 64'(rsp_b_q.size()), 64'(1));

    check("idle_fields_zero", 64'(idle_bad), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
